// File: rtl/uart_rx_fsm_if.sv
// UART receiver bundle: serial line in, received frame and status out.
// master drives the line and acknowledge; slave is the receiver.
interface uart_rx_fsm_if #(
  parameter int DATA_BITS = 8
);
  logic                 serial_in;
  logic                 clear_rx_flag;
  logic [DATA_BITS-1:0] rx_data;
  logic                 rx_flag;
  logic                 frame_error;
  logic                 parity_error;
  logic                 busy;

  modport master (
    output serial_in,
    output clear_rx_flag,
    input  rx_data,
    input  rx_flag,
    input  frame_error,
    input  parity_error,
    input  busy
  );

  modport slave (
    input  serial_in,
    input  clear_rx_flag,
    output rx_data,
    output rx_flag,
    output frame_error,
    output parity_error,
    output busy
  );
endinterface

// File: rtl/uart_rx_fsm.sv
// UART receive FSM, mid-bit sampling, LSB first, sticky rx_flag.
// Define UART_RX_PARITY_EN to expect one even-parity bit after the data.
module uart_rx_fsm #(
  parameter int CLKS_PER_BIT = 16,
  parameter int DATA_BITS    = 8
) (
  input logic        clk,
  input logic        reset,
  uart_rx_fsm_if.slave bus
);

  localparam int TW = $clog2(CLKS_PER_BIT);
  localparam int CW = $clog2(DATA_BITS + 1);

  localparam logic [TW-1:0] T_HALF = TW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [TW-1:0] T_FULL = TW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] N_LAST = CW'(DATA_BITS - 1);

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
`ifdef UART_RX_PARITY_EN
    PARITY,
`endif
    STOP
  } state_t;

  state_t               state, state_n;
  logic                 sync1, line_s, line_q;
  logic [TW-1:0]        timer, timer_n;
  logic [CW-1:0]        cnt, cnt_n;
  logic [DATA_BITS-1:0] sr, sr_n;
  logic                 stop_bit, stop_n;
  logic                 commit, commit_n;
  logic [DATA_BITS-1:0] data_q, data_n;
  logic                 flag_q, flag_n;
  logic                 fe_q, fe_n;
`ifdef UART_RX_PARITY_EN
  logic                 par_bit, par_n;
  logic                 pe_q, pe_n;
`endif

  logic tick_half, tick_full;

  assign tick_half = (timer == T_HALF);
  assign tick_full = (timer == T_FULL);

  always_comb begin
    state_n  = state;
    timer_n  = timer;
    cnt_n    = cnt;
    sr_n     = sr;
    stop_n   = stop_bit;
    commit_n = 1'b0;
    data_n   = data_q;
    flag_n   = flag_q & ~bus.clear_rx_flag;
    fe_n     = fe_q;
`ifdef UART_RX_PARITY_EN
    par_n    = par_bit;
    pe_n     = pe_q;
`endif
    unique case (state)
      IDLE: begin
        // edge, not level: a held-low break never restarts
        if (line_q && !line_s) begin
          state_n = START;
          timer_n = '0;
        end
      end
      START: begin
        if (tick_half) begin
          timer_n = '0;
          cnt_n   = '0;
          state_n = line_s ? IDLE : DATA;
        end else begin
          timer_n = timer + 1'b1;
        end
      end
      DATA: begin
        if (tick_full) begin
          timer_n = '0;
          cnt_n   = cnt + 1'b1;
          sr_n    = {line_s, sr[DATA_BITS-1:1]};
          if (cnt == N_LAST) begin
`ifdef UART_RX_PARITY_EN
            state_n = PARITY;
`else
            state_n = STOP;
`endif
          end
        end else begin
          timer_n = timer + 1'b1;
        end
      end
`ifdef UART_RX_PARITY_EN
      PARITY: begin
        if (tick_full) begin
          par_n   = line_s;
          timer_n = '0;
          state_n = STOP;
        end else begin
          timer_n = timer + 1'b1;
        end
      end
`endif
      STOP: begin
        // sample first, publish on the following edge
        if (commit) begin
          state_n = IDLE;
          timer_n = '0;
          cnt_n   = '0;
          data_n  = sr;
          flag_n  = 1'b1;
          fe_n    = ~stop_bit;
`ifdef UART_RX_PARITY_EN
          pe_n    = ^{sr, par_bit};
`endif
        end else if (tick_full) begin
          stop_n   = line_s;
          commit_n = 1'b1;
        end else begin
          timer_n = timer + 1'b1;
        end
      end
      default: begin
        state_n = IDLE;
        timer_n = '0;
        cnt_n   = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      sync1    <= 1'b1;
      line_s   <= 1'b1;
      line_q   <= 1'b1;
      state    <= IDLE;
      timer    <= '0;
      cnt      <= '0;
      sr       <= '0;
      stop_bit <= 1'b0;
      commit   <= 1'b0;
      data_q   <= '0;
      flag_q   <= 1'b0;
      fe_q     <= 1'b0;
`ifdef UART_RX_PARITY_EN
      par_bit  <= 1'b0;
      pe_q     <= 1'b0;
`endif
    end else begin
      sync1    <= bus.serial_in;
      line_s   <= sync1;
      line_q   <= line_s;
      state    <= state_n;
      timer    <= timer_n;
      cnt      <= cnt_n;
      sr       <= sr_n;
      stop_bit <= stop_n;
      commit   <= commit_n;
      data_q   <= data_n;
      flag_q   <= flag_n;
      fe_q     <= fe_n;
`ifdef UART_RX_PARITY_EN
      par_bit  <= par_n;
      pe_q     <= pe_n;
`endif
    end
  end

  assign bus.rx_data     = data_q;
  assign bus.rx_flag     = flag_q;
  assign bus.frame_error = fe_q;
  assign bus.busy        = (state != IDLE);
`ifdef UART_RX_PARITY_EN
  assign bus.parity_error = pe_q;
`else
  assign bus.parity_error = 1'b0;
`endif

endmodule

// File: tb/tb_uart_rx_fsm.sv
// Bench for uart_rx_fsm: directed frame table, corner sequences,
// and random frames against a frame-level reference model.
module tb_uart_rx_fsm;

  localparam int C = 16;
  localparam int D = 8;
`ifdef UART_RX_PARITY_EN
  localparam int PB = 1;
`else
  localparam int PB = 0;
`endif
  // drive-to-flag: 2 sync flops + edge detect, half bit, data/parity/stop bits, publish edge
  localparam int LAT = 3 + C / 2 + (D + 1 + PB) * C + 1;

  logic clk = 1'b0;
  logic reset = 1'b1;

  uart_rx_fsm_if #(.DATA_BITS(D)) bus();

  uart_rx_fsm #(
    .CLKS_PER_BIT(C),
    .DATA_BITS   (D)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int   rise_cnt = 0;
  int   rise_cyc = -1;
  logic flag_q = 1'b0;
  always @(negedge clk) begin
    if (bus.rx_flag === 1'b1 && flag_q !== 1'b1) begin
      rise_cnt++;
      rise_cyc = cyc;
    end
    flag_q = bus.rx_flag;
  end

  int vec = 0;
  int miss = 0;
  logic [7:0] last_d = 8'h00;

  typedef struct {
    logic [7:0] d;
    bit         stop;
    bit         par;
    int         hold;
    logic [7:0] xd;
    bit         xfe;
    bit         xpe;
  } vec_t;

  typedef struct {
    logic [7:0] d;
    bit         fe;
    bit         pe;
  } res_t;

  function automatic res_t model(input logic [7:0] d, input bit stop,
                                 input bit par);
    res_t r;
    int ones = 0;
    for (int i = 0; i < D; i++) ones += int'(d[i]);
    r.d  = d;
    r.fe = !stop;
    r.pe = (PB != 0) ? (((ones + int'(par)) % 2) != 0) : 1'b0;
    return r;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    vec++;
    if (act !== exp) begin
      miss++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  task automatic clk_n(input int n);
    if (n > 0) begin
      repeat (n) @(posedge clk);
      #1;
    end
  endtask

  task automatic pulse_clear();
    bus.clear_rx_flag = 1'b1;
    clk_n(1);
    bus.clear_rx_flag = 1'b0;
    clk_n(1);
  endtask

  task automatic send(input logic [7:0] d, input bit stop, input bit par,
                      input int hold, input int clr_off,
                      output int lat, output int rises);
    int start;
    int r0;
    pulse_clear();
    start = cyc;
    r0 = rise_cnt;
    fork
      begin
        bus.serial_in = 1'b0;
        clk_n(C);
        for (int i = 0; i < D; i++) begin
          bus.serial_in = d[i];
          clk_n(C);
        end
        if (PB != 0) begin
          bus.serial_in = par;
          clk_n(C);
        end
        bus.serial_in = stop;
        clk_n(C);
        if (!stop) clk_n(hold * C);
        bus.serial_in = 1'b1;
        clk_n(2 * C);
      end
      begin
        if (clr_off >= 0) begin
          clk_n(clr_off);
          bus.clear_rx_flag = 1'b1;
          clk_n(1);
          bus.clear_rx_flag = 1'b0;
        end
      end
    join
    rises = rise_cnt - r0;
    lat = (rises > 0) ? rise_cyc - start : -1;
  endtask

  task automatic frame_check(input string tag, input logic [7:0] d,
                             input bit stop, input bit par, input int hold,
                             input logic [7:0] xd, input bit xfe,
                             input bit xpe);
    int lat;
    int rises;
    send(d, stop, par, hold, -1, lat, rises);
    chk({tag, ".data"}, 32'(bus.rx_data), 32'(xd));
    chk({tag, ".ferr"}, 32'(bus.frame_error), 32'(xfe));
    chk({tag, ".perr"}, 32'(bus.parity_error), 32'(xpe));
    chk({tag, ".flag"}, 32'(bus.rx_flag), 32'd1);
    chk({tag, ".rises"}, 32'(rises), 32'd1);
    chk({tag, ".lat"}, 32'(lat), 32'(LAT));
    chk({tag, ".busy"}, 32'(bus.busy), 32'd0);
    last_d = xd;
  endtask

  vec_t tbl[6];

  initial begin
    int   lat;
    int   rises;
    int   r0;
    res_t m;
    logic [7:0] rd;
    bit   rs;
    bit   rp;

    tbl[0] = '{8'hA5, 1'b1, 1'b0, 0,   8'hA5, 1'b0, 1'b0};
    tbl[1] = '{8'h3C, 1'b0, 1'b0, 100, 8'h3C, 1'b1, 1'b0};
    tbl[2] = '{8'h07, 1'b1, 1'b1, 0,   8'h07, 1'b0, 1'b0};
    tbl[3] = '{8'h07, 1'b1, 1'b0, 0,   8'h07, 1'b0, 1'(PB)};
    tbl[4] = '{8'h00, 1'b1, 1'b1, 0,   8'h00, 1'b0, 1'(PB)};
    tbl[5] = '{8'hFF, 1'b0, 1'b0, 0,   8'hFF, 1'b1, 1'b0};

    bus.serial_in = 1'b1;
    bus.clear_rx_flag = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst.data", 32'(bus.rx_data), 32'd0);
    chk("rst.flag", 32'(bus.rx_flag), 32'd0);
    chk("rst.ferr", 32'(bus.frame_error), 32'd0);
    chk("rst.perr", 32'(bus.parity_error), 32'd0);
    chk("rst.busy", 32'(bus.busy), 32'd0);
    reset = 1'b0;
    clk_n(2 * C);

    for (int i = 0; i < 6; i++)
      frame_check($sformatf("tbl%0d", i), tbl[i].d, tbl[i].stop, tbl[i].par,
                  tbl[i].hold, tbl[i].xd, tbl[i].xfe, tbl[i].xpe);

    // reset in the middle of data bit 4
    r0 = rise_cnt;
    bus.serial_in = 1'b0;
    clk_n(C);
    for (int i = 0; i < 4; i++) begin
      bus.serial_in = rd_bit(8'h5A, i);
      clk_n(C);
    end
    bus.serial_in = 1'b1;
    clk_n(C / 2);
    chk("mid.busy", 32'(bus.busy), 32'd1);
    reset = 1'b1;
    clk_n(1);
    reset = 1'b0;
    chk("mrst.data", 32'(bus.rx_data), 32'd0);
    chk("mrst.flag", 32'(bus.rx_flag), 32'd0);
    chk("mrst.ferr", 32'(bus.frame_error), 32'd0);
    chk("mrst.perr", 32'(bus.parity_error), 32'd0);
    chk("mrst.busy", 32'(bus.busy), 32'd0);
    clk_n(3 * C);
    chk("mrst.idle", 32'(bus.busy), 32'd0);
    chk("mrst.rises", 32'(rise_cnt - r0), 32'd0);
    last_d = 8'h00;
    frame_check("r81", 8'h81, 1'b1, 1'b0, 0, 8'h81, 1'b0, 1'b0);

    // start glitch shorter than half a bit
    pulse_clear();
    r0 = rise_cnt;
    bus.serial_in = 1'b0;
    clk_n(4);
    chk("glitch.busy", 32'(bus.busy), 32'd1);
    bus.serial_in = 1'b1;
    clk_n(3 * C);
    chk("glitch.flag", 32'(bus.rx_flag), 32'd0);
    chk("glitch.data", 32'(bus.rx_data), 32'(last_d));
    chk("glitch.busy2", 32'(bus.busy), 32'd0);
    chk("glitch.rises", 32'(rise_cnt - r0), 32'd0);

    // acknowledge on the publish edge loses; one edge later wins
    send(8'h5A, 1'b1, 1'b0, 0, LAT - 1, lat, rises);
    chk("clr0.flag", 32'(bus.rx_flag), 32'd1);
    chk("clr0.lat", 32'(lat), 32'(LAT));
    chk("clr0.data", 32'(bus.rx_data), 32'h5A);
    send(8'hC3, 1'b1, 1'b0, 0, LAT, lat, rises);
    chk("clr1.flag", 32'(bus.rx_flag), 32'd0);
    chk("clr1.rises", 32'(rises), 32'd1);
    chk("clr1.data", 32'(bus.rx_data), 32'hC3);
    last_d = 8'hC3;

    for (int i = 0; i < 16; i++) begin
      rd = 8'($urandom);
      rs = ($urandom % 4) != 0;
      rp = 1'($urandom);
      clk_n(int'($urandom_range(0, 40)));
      m = model(rd, rs, rp);
      frame_check($sformatf("rnd%0d", i), rd, rs, rp, 0, m.d, m.fe, m.pe);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vec, miss);
    $finish;
  end

  function automatic logic rd_bit(input logic [7:0] v, input int i);
    return v[i];
  endfunction

endmodule
